// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// source indices, IRQ codes and the fixed-priority arbiter.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_t;

  localparam int SRC_KBD = 0;
  localparam int SRC_TMR = 1;
  localparam int SRC_GPU = 2;

  localparam logic [1:0] IRQ_NONE = 2'b00;
  localparam logic [1:0] IRQ_KBD  = 2'b01;
  localparam logic [1:0] IRQ_TMR  = 2'b10;
  localparam logic [1:0] IRQ_GPU  = 2'b11;

  // Fixed priority: GPU over timer over keyboard.
  function automatic logic [1:0] arbitrate(input logic [2:0] eligible);
    if (eligible[SRC_GPU])      return IRQ_GPU;
    else if (eligible[SRC_TMR]) return IRQ_TMR;
    else if (eligible[SRC_KBD]) return IRQ_KBD;
    else                        return IRQ_NONE;
  endfunction

  function automatic logic [2:0] code_to_onehot(input logic [1:0] code);
    case (code)
      IRQ_KBD: return 3'b001;
      IRQ_TMR: return 3'b010;
      IRQ_GPU: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/int_timer.sv
// Free-running interval timer: counts 0..PERIOD-1 and pulses TICK for one
// cycle on the last count, just before it wraps.
module int_timer #(
  parameter logic [15:0] PERIOD = 16'd50000
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  logic [15:0] count;

  assign TICK = (count == PERIOD - 16'd1);

  always_ff @(posedge CLK) begin
    if (RESET)     count <= '0;
    else if (TICK) count <= '0;
    else           count <= count + 16'd1;
  end

endmodule

// File: rtl/int_controller.sv
// Three-source prioritised interrupt controller with IACK/IEND handshake.
// Define INT_CTRL_TIMER_EN to drive source 1 from the internal int_timer.
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMER_PERIOD = 16'd50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [2:0] SRC_REQ,
  input  logic [2:0] SRC_MASK,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic       INT_OVERRUN
);

  state_t     state;
  logic [2:0] req_q;
  logic [2:0] pending;
  logic [2:0] set_vec;
  logic [2:0] clr_vec;
  logic [2:0] eligible;

`ifdef INT_CTRL_TIMER_EN
  logic tick;

  int_timer #(.PERIOD(TIMER_PERIOD)) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (tick)
  );

  // The timer tick pends source 1 directly; SRC_REQ[1] is not looked at.
  assign set_vec = {SRC_REQ[SRC_GPU] & ~req_q[SRC_GPU], tick,
                    SRC_REQ[SRC_KBD] & ~req_q[SRC_KBD]};
`else
  assign set_vec = SRC_REQ & ~req_q;
`endif

  assign eligible = pending & ~SRC_MASK;

  // The winner is identified by the code latched on INT_IRQ, so masking or
  // new arrivals mid-handshake cannot change which bit gets cleared.
  always_comb begin
    clr_vec = '0;
    if (state == ASSERT && INT_IACK) clr_vec = code_to_onehot(INT_IRQ);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; reset is synchronous, hence not in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_q       <= '0;
      pending     <= '0;
      INT_OVERRUN <= 1'b0;
    end else begin
      req_q       <= SRC_REQ;
      // A set coinciding with its own clear wins and is not an overrun.
      pending     <= (pending & ~clr_vec) | set_vec;
      INT_OVERRUN <= |(set_vec & pending & ~clr_vec);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      INT_IRQ <= IRQ_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (ENABLE && |eligible) begin
            INT_IRQ <= arbitrate(eligible);
            state   <= ASSERT;
          end
        end
        ASSERT: begin
          if (INT_IACK) state <= SERVICE;
        end
        SERVICE: begin
          if (INT_IEND) begin
            INT_IRQ <= IRQ_NONE;
            state   <= IDLE;
          end
        end
        default: begin
          INT_IRQ <= IRQ_NONE;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller; the INT_CTRL_TIMER_EN
// build runs the interval-timer scenario instead of the edge-source ones.
module tb_int_controller;

`ifdef INT_CTRL_TIMER_EN
  localparam logic [15:0] TP = 16'd8;
`else
  localparam logic [15:0] TP = 16'd50000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] src_req;
  logic [2:0] src_mask;
  logic [1:0] irq;
  logic       iack;
  logic       iend;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int_controller #(.TIMER_PERIOD(TP)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .ENABLE      (enable),
    .SRC_REQ     (src_req),
    .SRC_MASK    (src_mask),
    .INT_IRQ     (irq),
    .INT_IACK    (iack),
    .INT_IEND    (iend),
    .INT_OVERRUN (overrun)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_iack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  task automatic pulse_iend();
    iend = 1'b1;
    tick();
    iend = 1'b0;
  endtask

  // Raise the given source lines for one sampled edge, then drop them.
  task automatic edge_src(input logic [2:0] bits);
    src_req = bits;
    tick();
    src_req = 3'b000;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    src_req  = 3'b000;
    src_mask = 3'b000;
    iack     = 1'b0;
    iend     = 1'b0;
    repeat (3) tick();
    check("reset_irq", irq, 2'b00);
    check("reset_overrun", overrun, 1'b0);
    reset = 1'b0;
    tick();

`ifdef INT_CTRL_TIMER_EN
    begin
      int rec;
      bit found;
      found = 0;
      rec   = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        src_req[1] = ~src_req[1];
        tick();
        if (irq == 2'b10) begin found = 1; rec = cyc; end
      end
      check("tmr_first", found, 1'b1);
      for (int k = 0; k < 3; k++) begin
        src_req[1] = ~src_req[1];
        pulse_iack();
        check("tmr_held", irq, 2'b10);
        src_req[1] = ~src_req[1];
        pulse_iend();
        check("tmr_end", irq, 2'b00);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
          src_req[1] = ~src_req[1];
          tick();
          if (irq != 2'b00) found = 1;
        end
        check("tmr_again", {30'd0, irq}, 32'd2);
        check("tmr_interval", cyc - rec, 8);
        rec = cyc;
      end
    end
`else
    // Keyboard: two-cycle latency, held through IACK, cleared by IEND.
    src_req = 3'b001;
    tick();
    src_req = 3'b000;
    check("kbd_pend_only", irq, 2'b00);
    tick();
    check("kbd_latency2", irq, 2'b01);
    tick(); tick();
    check("kbd_hold", irq, 2'b01);
    pulse_iack();
    check("kbd_after_iack", irq, 2'b01);
    tick(); tick();
    pulse_iend();
    check("kbd_after_iend", irq, 2'b00);
    tick();
    check("kbd_no_repeat", irq, 2'b00);

    // Stray handshake pulses in IDLE do nothing.
    pulse_iend();
    pulse_iack();
    tick();
    check("idle_stray", irq, 2'b00);

    // Simultaneous GPU and keyboard: GPU first, keyboard right after.
    edge_src(3'b101);
    tick();
    check("gpu_first", irq, 2'b11);
    pulse_iend();
    check("iend_in_assert", irq, 2'b11);
    pulse_iack();
    check("gpu_service", irq, 2'b11);
    pulse_iend();
    check("gpu_done", irq, 2'b00);
    tick();
    check("kbd_after_gpu", irq, 2'b01);
    pulse_iack();
    pulse_iend();
    tick();
    check("both_done", irq, 2'b00);

    // Repeated keyboard edge before IACK: one overrun, one service.
    edge_src(3'b001);
    check("ovr_first_edge", overrun, 1'b0);
    tick();
    check("ovr_assert", irq, 2'b01);
    edge_src(3'b001);
    check("ovr_pulse", overrun, 1'b1);
    tick();
    check("ovr_one_cycle", overrun, 1'b0);
    pulse_iack();
    pulse_iend();
    tick();
    check("kbd_once", irq, 2'b00);

    // Edge coinciding with its own IACK clear: stays pending, no overrun.
    edge_src(3'b001);
    tick();
    src_req = 3'b001;
    pulse_iack();
    src_req = 3'b000;
    check("set_wins_no_ovr", overrun, 1'b0);
    pulse_iend();
    tick();
    check("set_wins_repend", irq, 2'b01);
    pulse_iack();
    pulse_iend();

    // Masked GPU stays quiet; unmasking presents it within two cycles.
    src_mask = 3'b100;
    edge_src(3'b100);
    tick(); tick();
    check("gpu_masked", irq, 2'b00);
    src_mask = 3'b000;
    tick();
    check("gpu_unmasked", irq, 2'b11);
    src_mask = 3'b100;
    tick();
    check("mask_mid_assert", irq, 2'b11);
    pulse_iack();
    check("mask_mid_service", irq, 2'b11);
    pulse_iend();
    src_mask = 3'b000;
    tick();
    check("mask_done", irq, 2'b00);

    // ENABLE low holds the pending bit without presenting it.
    enable = 1'b0;
    edge_src(3'b001);
    tick(); tick();
    check("disabled", irq, 2'b00);
    enable = 1'b1;
    tick();
    check("enabled", irq, 2'b01);
    pulse_iack();
    pulse_iend();

    // Timer source beats keyboard.
    edge_src(3'b011);
    tick();
    check("tmr_over_kbd", irq, 2'b10);
    pulse_iack();
    pulse_iend();
    tick();
    check("kbd_after_tmr", irq, 2'b01);
    pulse_iack();
    pulse_iend();

    // Reset during SERVICE drops the handshake and the pending keyboard.
    edge_src(3'b101);
    tick();
    pulse_iack();
    check("pre_reset_service", irq, 2'b11);
    reset = 1'b1;
    tick();
    check("reset_mid_irq", irq, 2'b00);
    reset = 1'b0;
    tick(); tick();
    check("reset_cleared_pend", irq, 2'b00);
    pulse_iend();
    tick();
    check("iend_after_reset", irq, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter TIMER_PERIOD, default 16'd50000, number of CLK cycles between internal timer ticks; legal range 2..65535.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 ENABLE  input  1  low: pending sources are held but no new request is presented; the current handshake still completes.
REQ-005 SRC_REQ  input  3  raw request lines, level; bit0 keyboard, bit1 timer/external, bit2 GPU frame-done.
REQ-006 SRC_MASK  input  3  1 = source masked, so it is never selected while masked; its pending bit still latches.
REQ-007 INT_IRQ  output  2  request code to processor: 00 none, 01 keyboard, 10 timer, 11 GPU.
REQ-008 INT_IACK  input  1  processor acknowledge, 1-cycle pulse.
REQ-009 INT_IEND  input  1  processor end-of-service, 1-cycle pulse.
REQ-010 INT_OVERRUN  output  1  1-cycle pulse when a source edge arrives while its pending bit is already set.

Function
REQ-011 A rising edge on any SRC_REQ bit (registered previous value 0, current 1) shall set the matching pending bit in the same clock edge.
REQ-012 Priority shall be fixed: GPU (2) > timer (1) > keyboard (0); selection shall consider only pending AND NOT masked bits.
REQ-013 FSM states shall be IDLE, ASSERT and SERVICE.
REQ-014 IDLE: INT_IRQ = 00; if ENABLE and any eligible bit is set, latch the winner's code and enter ASSERT next cycle.
REQ-015 ASSERT: INT_IRQ = latched code; on INT_IACK, clear the winner's pending bit and enter SERVICE; the code is not re-arbitrated while in ASSERT.
REQ-016 SERVICE: INT_IRQ = latched code; on INT_IEND, enter IDLE; a new request appears at the earliest 1 cycle after IEND.
REQ-017 INT_IACK outside ASSERT and INT_IEND outside SERVICE shall be ignored.
REQ-018 A new edge on the winner's source in the same cycle as its IACK clear: the set shall win, so the bit stays pending, and no overrun is reported.
REQ-019 A repeated edge on an already-pending source shall be merged, not queued, and shall pulse INT_OVERRUN.
REQ-020 Latency from a SRC_REQ rising edge to a nonzero INT_IRQ shall be 2 cycles when the FSM is in IDLE: one cycle to pend, one to arbitrate.
REQ-021 Masking a source while it is in ASSERT or SERVICE shall not abort the handshake.

Reset
REQ-022 While RESET is asserted: pending = 000, edge registers = 000, state = IDLE, INT_IRQ = 00, INT_OVERRUN = 0, timer counter = 0.
REQ-023 RESET mid-handshake shall abandon the handshake; the processor shall not see IRQ nonzero until a fresh edge occurs after reset.

Configuration
REQ-024 With macro INT_CTRL_TIMER_EN defined, source 1 shall be driven by the internal interval timer and SRC_REQ[1] shall be ignored.
REQ-025 The timer counts 0..TIMER_PERIOD-1 and produces a 1-cycle tick on wrap; the tick sets pending bit 1 directly, with no edge detect.
REQ-026 Without INT_CTRL_TIMER_EN, no timer logic shall be synthesised and source 1 shall be SRC_REQ[1] edge-detected like the other sources.

Structure
REQ-027 Package int_ctrl_pkg shall hold the state enum (IDLE/ASSERT/SERVICE), the source index constants (SRC_KBD=0, SRC_TMR=1, SRC_GPU=2) and the IRQ code constants (IRQ_NONE=00, IRQ_KBD=01, IRQ_TMR=10, IRQ_GPU=11).
REQ-028 The interval timer shall be a sub-module int_timer (CLK, RESET, TICK), instantiated only under INT_CTRL_TIMER_EN.

Verification
REQ-029 Keyboard edge at cycle 10 -> INT_IRQ=01 at cycle 12; IACK at cycle 15 -> IRQ held at 01; IEND at cycle 18 -> IRQ=00 at cycle 19.
REQ-030 Keyboard and GPU edges in the same cycle -> IRQ=11 first; after IACK+IEND -> IRQ=01 one cycle after IDLE is re-entered.
REQ-031 Two keyboard edges before IACK -> one INT_OVERRUN pulse, and exactly one keyboard service follows.
REQ-032 SRC_MASK=100 with GPU edge -> IRQ stays 00; clear the mask -> IRQ=11 within 2 cycles.
REQ-033 RESET asserted during SERVICE -> next cycle IRQ=00 and pending=000; a subsequent IEND is ignored.
REQ-034 With INT_CTRL_TIMER_EN and TIMER_PERIOD=8 -> IRQ=10 every 8 cycles under immediate IACK/IEND, and SRC_REQ[1] toggling has no effect.
